mux16_rr_arbiter: RTL

//  Round-robin arbiter that shares one 16:1 bit-select path between 16 requesters.

---
 rtl/mux16_rr_arbiter_pkg.sv | 20 ++
 rtl/mux16_rr_arbiter_if.sv | 28 ++
 rtl/mux16_rr_arbiter_pick.sv | 26 ++
 rtl/mux16to1.sv | 10 +
 rtl/mux16_rr_arbiter.sv | 117 +++++++++++
 5 files changed

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants, state encoding and request-vector type for the 16-way
// round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef logic [NREQ-1:0] req_vec_t;

    function automatic req_vec_t onehot(input logic [SEL_W-1:0] idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux16_rr_arbiter_if;
    import mux_arb_pkg::*;

    // Handshake: req[i] is a level held high for as long as requester i wants
    // the path; gnt[i] (one-hot, registered) says it owns it this cycle. A
    // requester drops req[i] to give the path back; nothing is latched, so a
    // request that falls before being granted is forgotten.
    req_vec_t         req;
    req_vec_t         data_in;
    req_vec_t         gnt;
    logic             gnt_valid;
    logic [SEL_W-1:0] sel;
    logic             data_out;
    logic             out_valid;
    arb_state_t       dbg_state;

    modport master (
        output req, data_in,
        input  gnt, gnt_valid, sel, data_out, out_valid, dbg_state
    );

    modport slave (
        input  req, data_in,
        output gnt, gnt_valid, sel, data_out, out_valid, dbg_state
    );

endinterface

// File: rtl/mux16_rr_arbiter_pick.sv
// Round-robin winner search: first set request at or after ptr, wrapping mod 16.
module rr_pick16
    import mux_arb_pkg::*;
(
    input  req_vec_t         req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    req_vec_t         rot;
    logic [SEL_W-1:0] off;

    // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotate.
    always_comb begin
        rot = (req >> ptr) | (req << (NREQ - int'(ptr)));
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule

// File: rtl/mux16to1.sv
// Plain 16:1 single-bit mux; the datapath cell the arbiter steers.
module mux16to1 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner of a shared 16:1 bit-select path with hold limit and
// optional dead cycle between owners; data bit is registered during GRANT.
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int GAP_EN   = 1
) (
    input logic               clk,
    input logic               rst,
    mux16_rr_arbiter_if.slave bus
);

    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] win_idx;
    logic             win_any;
    logic             mux_bit;
    logic [HW-1:0]    hold_cnt;
    req_vec_t         gnt_q;
    logic             gnt_valid_q;
    logic             data_q;
    logic             out_valid_q;
    logic             hold_done;
    logic             release_now;

    // On a release edge the search must already use the advanced pointer so
    // that a back-to-back handover sees the previous owner last.
    assign pick_ptr    = (state == GRANT) ? sel_q + 1'b1 : ptr;
    assign hold_done   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = !bus.req[sel_q] || hold_done;

    rr_pick16 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .any (win_any),
        .idx (win_idx)
    );

    mux16to1 u_mux (
        .in  (bus.data_in),
        .sel (sel_q),
        .out (mux_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            sel_q       <= '0;
            data_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (win_any) begin
                        gnt_q       <= onehot(win_idx);
                        gnt_valid_q <= 1'b1;
                        sel_q       <= win_idx;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    data_q      <= mux_bit;
                    out_valid_q <= 1'b1;
                    // Saturates only in the unlimited-hold build.
                    if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                    if (release_now) begin
                        ptr <= pick_ptr;
                        if (GAP_EN != 0) begin
                            gnt_q       <= '0;
                            gnt_valid_q <= 1'b0;
                            state       <= GAP;
                        end else if (win_any) begin
                            gnt_q       <= onehot(win_idx);
                            gnt_valid_q <= 1'b1;
                            sel_q       <= win_idx;
                            hold_cnt    <= '0;
                        end else begin
                            gnt_q       <= '0;
                            gnt_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                GAP: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.sel       = sel_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dbg_state = state;

endmodule
